// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan controller.
package adc_pkg;

   localparam int ADC_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      EMIT
   } state_t;

   // Divide an accumulated sum by 2^log2 (truncating) and keep the ADC-width result.
   // The sum is passed zero-extended to ADC_W+4 bits, the widest accumulator allowed.
   function automatic logic [ADC_W-1:0] avg_shift(input logic [ADC_W+3:0] sum, input int log2);
      logic [ADC_W+3:0] shifted;
      shifted = sum >> log2;
      return shifted[ADC_W-1:0];
   endfunction

endpackage

// File: rtl/adc_ch_find.sv
// Combinational channel finder: next enabled channel above the current one,
// and the lowest enabled channel of the mask.
module adc_ch_find #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [CH_W-1:0]   i_cur,
   output logic [CH_W-1:0]   o_next_idx,
   output logic              o_next_found,
   output logic [CH_W-1:0]   o_low_idx
);

   // Scan from the top down so the last hit is the lowest qualifying index.
   always_comb begin
      o_next_idx   = '0;
      o_next_found = 1'b0;
      o_low_idx    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_low_idx = CH_W'(i);
            if (i > int'(i_cur)) begin
               o_next_idx   = CH_W'(i);
               o_next_found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multiplexed ADC scan sequencer: selects channels, drops conversions that
// straddle a mux change, averages good conversions and emits tagged results.
module adc_scan_ctrl
   import adc_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CH_W     = 2,
   parameter int DISCARD  = 1,
   parameter int AVG_LOG2 = 2
) (
   input  logic              i_clk,
   input  logic              i_res,
   input  logic              i_start,
   input  logic              i_continuous,
   input  logic [NUM_CH-1:0] i_en_mask,
   input  logic [ADC_W-1:0]  i_adc_val,
   input  logic              i_adc_done,
   output logic [CH_W-1:0]   o_mux_sel,
   output logic              o_busy,
   output logic              o_smp_valid,
   output logic [CH_W-1:0]   o_smp_ch,
   output logic [ADC_W-1:0]  o_smp_val,
   input  logic              i_smp_ready,
   output logic              o_scan_done
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] DISC_LAST = CNT_W'(DISCARD - 1);
   localparam logic [CNT_W-1:0] AVG_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [CH_W-1:0]     mux_sel_q, mux_sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                smp_valid_q, smp_valid_d;
   logic [CH_W-1:0]     smp_ch_q, smp_ch_d;
   logic [ADC_W-1:0]    smp_val_q, smp_val_d;
   logic                scan_done_q, scan_done_d;
   logic [ACC_W-1:0]    sum;

   logic [CH_W-1:0]     next_idx;
   logic                next_found;
   logic [CH_W-1:0]     unused_latched_low;
   logic [CH_W-1:0]     new_low_idx;
   logic [CH_W-1:0]     unused_new_next_idx;
   logic                unused_new_next_found;

   // Walks the latched mask upward from the channel currently selected.
   adc_ch_find #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_find_next (
      .i_mask       (mask_q),
      .i_cur        (mux_sel_q),
      .o_next_idx   (next_idx),
      .o_next_found (next_found),
      .o_low_idx    (unused_latched_low)
   );

   // Finds the first channel of the live mask for a fresh start or a rescan.
   adc_ch_find #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_find_low (
      .i_mask       (i_en_mask),
      .i_cur        (mux_sel_q),
      .o_next_idx   (unused_new_next_idx),
      .o_next_found (unused_new_next_found),
      .o_low_idx    (new_low_idx)
   );

   // State register and all datapath flops; reset drops any partial sum or pending result.
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         mux_sel_q   <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         smp_valid_q <= 1'b0;
         smp_ch_q    <= '0;
         smp_val_q   <= '0;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         mux_sel_q   <= mux_sel_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         smp_valid_q <= smp_valid_d;
         smp_ch_q    <= smp_ch_d;
         smp_val_q   <= smp_val_d;
         scan_done_q <= scan_done_d;
      end
   end

   // Next-state and datapath logic for the settle / sample / emit sequence.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      mux_sel_d   = mux_sel_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      smp_valid_d = smp_valid_q;
      smp_ch_d    = smp_ch_q;
      smp_val_d   = smp_val_q;
      scan_done_d = 1'b0;
      sum         = acc_q + ACC_W'(i_adc_val);

      case (state_q)
         IDLE: begin
            if (i_start && (|i_en_mask)) begin
               mask_d    = i_en_mask;
               mux_sel_d = new_low_idx;
               cnt_d     = '0;
               state_d   = SETTLE;
            end
         end

         SETTLE: begin
            if (i_adc_done) begin
               if (cnt_q == DISC_LAST) begin
                  cnt_d   = '0;
                  acc_d   = '0;
                  state_d = SAMPLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         SAMPLE: begin
            if (i_adc_done) begin
               if (cnt_q == AVG_LAST) begin
                  smp_val_d   = avg_shift((ADC_W + 4)'(sum), AVG_LOG2);
                  smp_ch_d    = mux_sel_q;
                  smp_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = EMIT;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         EMIT: begin
            if (i_smp_ready) begin
               smp_valid_d = 1'b0;
               cnt_d       = '0;
               acc_d       = '0;
               if (next_found) begin
                  mux_sel_d = next_idx;
                  state_d   = SETTLE;
               end else begin
                  scan_done_d = 1'b1;
                  if (i_continuous) begin
                     mask_d = i_en_mask;
                     if (|i_en_mask) begin
                        mux_sel_d = new_low_idx;
                        state_d   = (new_low_idx == mux_sel_q) ? SAMPLE : SETTLE;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign o_mux_sel   = mux_sel_q;
   assign o_busy      = (state_q != IDLE);
   assign o_smp_valid = smp_valid_q;
   assign o_smp_ch    = smp_ch_q;
   assign o_smp_val   = smp_val_q;
   assign o_scan_done = scan_done_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed self-checking bench for the ADC scan controller.
module tb_adc_scan_ctrl;

   logic       i_clk;
   logic       i_res;
   logic       i_start;
   logic       i_continuous;
   logic [3:0] i_en_mask;
   logic [9:0] i_adc_val;
   logic       i_adc_done;
   logic [1:0] o_mux_sel;
   logic       o_busy;
   logic       o_smp_valid;
   logic [1:0] o_smp_ch;
   logic [9:0] o_smp_val;
   logic       i_smp_ready;
   logic       o_scan_done;

   int checkCount = 0;
   int errorCount = 0;
   int scanDoneCount = 0;
   int handshakeCount = 0;

   adc_scan_ctrl #(.NUM_CH(4), .CH_W(2), .DISCARD(1), .AVG_LOG2(2)) dut (
      .i_clk        (i_clk),
      .i_res        (i_res),
      .i_start      (i_start),
      .i_continuous (i_continuous),
      .i_en_mask    (i_en_mask),
      .i_adc_val    (i_adc_val),
      .i_adc_done   (i_adc_done),
      .o_mux_sel    (o_mux_sel),
      .o_busy       (o_busy),
      .o_smp_valid  (o_smp_valid),
      .o_smp_ch     (o_smp_ch),
      .o_smp_val    (o_smp_val),
      .i_smp_ready  (i_smp_ready),
      .o_scan_done  (o_scan_done)
   );

   // Free-running 100 MHz clock.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Count scan-done pulses and result handshakes mid-cycle, away from the active edge.
   always @(negedge i_clk) begin
      if (!i_res) begin
         if (o_scan_done) scanDoneCount++;
         if (o_smp_valid && i_smp_ready) handshakeCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge i_clk);
      #1;
   endtask

   // One ADC conversion-done pulse carrying the given value.
   task automatic applyStimulus(input logic [9:0] val);
      i_adc_val  = val;
      i_adc_done = 1'b1;
      stepCycle();
      i_adc_done = 1'b0;
   endtask

   task automatic startScan(input logic [3:0] mask);
      i_en_mask = mask;
      i_start   = 1'b1;
      stepCycle();
      i_start   = 1'b0;
   endtask

   task automatic handshake();
      i_smp_ready = 1'b1;
      stepCycle();
      i_smp_ready = 1'b0;
   endtask

   initial begin
      i_res        = 1'b1;
      i_start      = 1'b0;
      i_continuous = 1'b0;
      i_en_mask    = 4'b0000;
      i_adc_val    = '0;
      i_adc_done   = 1'b0;
      i_smp_ready  = 1'b0;
      repeat (2) stepCycle();
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_valid", o_smp_valid, 0);
      checkOutput("rst_mux", o_mux_sel, 0);
      checkOutput("rst_ch", o_smp_ch, 0);
      checkOutput("rst_val", o_smp_val, 0);
      checkOutput("rst_done", o_scan_done, 0);
      i_res = 1'b0;
      stepCycle();

      // Reset in the middle of SAMPLE, then a clean scan of zeros.
      startScan(4'b0100);
      checkOutput("t1_mux2", o_mux_sel, 2);
      checkOutput("t1_busy", o_busy, 1);
      applyStimulus(10'd500);
      applyStimulus(10'd800);
      applyStimulus(10'd800);
      i_res = 1'b1;
      repeat (3) stepCycle();
      checkOutput("t1_rst_busy", o_busy, 0);
      checkOutput("t1_rst_mux", o_mux_sel, 0);
      checkOutput("t1_rst_valid", o_smp_valid, 0);
      i_res = 1'b0;
      stepCycle();
      checkOutput("t1_idle", o_busy, 0);
      startScan(4'b0001);
      checkOutput("t1_mux0", o_mux_sel, 0);
      applyStimulus(10'd700);
      repeat (4) applyStimulus(10'd0);
      checkOutput("t1_valid", o_smp_valid, 1);
      checkOutput("t1_val", o_smp_val, 0);
      checkOutput("t1_ch", o_smp_ch, 0);
      handshake();
      checkOutput("t1_scan_done", o_scan_done, 1);
      checkOutput("t1_end_busy", o_busy, 0);
      stepCycle();
      checkOutput("t1_done_pulse", o_scan_done, 0);

      // Single scan of channels 1 and 3 with a backpressure window.
      startScan(4'b1010);
      checkOutput("t2_mux1", o_mux_sel, 1);
      applyStimulus(10'd999);
      applyStimulus(10'd100);
      applyStimulus(10'd101);
      applyStimulus(10'd102);
      checkOutput("t2_not_yet", o_smp_valid, 0);
      applyStimulus(10'd103);
      checkOutput("t2_valid", o_smp_valid, 1);
      checkOutput("t2_ch", o_smp_ch, 1);
      checkOutput("t2_val", o_smp_val, 101);
      for (int i = 0; i < 50; i++) begin
         if (i == 10 || i == 20 || i == 30) applyStimulus(10'd5);
         else stepCycle();
         checkOutput("t2_bp_hold", {o_smp_valid, o_smp_ch, o_smp_val, o_mux_sel},
                     {1'b1, 2'd1, 10'd101, 2'd1});
      end
      checkOutput("t2_bp_hs", handshakeCount, 1);
      handshake();
      checkOutput("t2_after_hs_valid", o_smp_valid, 0);
      checkOutput("t2_mux3", o_mux_sel, 3);
      checkOutput("t2_no_done", o_scan_done, 0);
      checkOutput("t2_busy", o_busy, 1);
      checkOutput("t2_one_hs", handshakeCount, 2);
      applyStimulus(10'd7);
      i_start = 1'b1;
      stepCycle();
      i_start = 1'b0;
      repeat (4) applyStimulus(10'd1023);
      checkOutput("t2_valid3", o_smp_valid, 1);
      checkOutput("t2_ch3", o_smp_ch, 3);
      checkOutput("t2_val3", o_smp_val, 1023);
      handshake();
      checkOutput("t2_scan_done", o_scan_done, 1);
      checkOutput("t2_idle", o_busy, 0);
      stepCycle();

      // Starts that must be ignored, and done pulses while idle.
      startScan(4'b0000);
      checkOutput("t3_mask0", o_busy, 0);
      applyStimulus(10'd5);
      checkOutput("t3_done_idle", o_busy, 0);
      checkOutput("t3_no_valid", o_smp_valid, 0);

      // Continuous scan of a single channel: no discard after the first result.
      i_continuous = 1'b1;
      startScan(4'b0001);
      applyStimulus(10'd1);
      applyStimulus(10'd10);
      applyStimulus(10'd20);
      applyStimulus(10'd30);
      applyStimulus(10'd40);
      checkOutput("t4_val_a", o_smp_val, 25);
      handshake();
      checkOutput("t4_done_a", o_scan_done, 1);
      checkOutput("t4_busy_a", o_busy, 1);
      checkOutput("t4_mux_a", o_mux_sel, 0);
      applyStimulus(10'd1);
      applyStimulus(10'd2);
      applyStimulus(10'd3);
      applyStimulus(10'd4);
      checkOutput("t4_valid_b", o_smp_valid, 1);
      checkOutput("t4_val_b", o_smp_val, 2);
      handshake();
      checkOutput("t4_done_b", o_scan_done, 1);
      applyStimulus(10'd1023);
      applyStimulus(10'd1023);
      applyStimulus(10'd1023);
      applyStimulus(10'd1022);
      checkOutput("t4_val_c", o_smp_val, 1022);
      checkOutput("t4_ch_c", o_smp_ch, 0);
      i_continuous = 1'b0;
      handshake();
      checkOutput("t4_done_c", o_scan_done, 1);
      checkOutput("t4_idle", o_busy, 0);
      stepCycle();

      // Mask changes during a continuous scan take effect only at the rescan.
      i_continuous = 1'b1;
      startScan(4'b0011);
      i_en_mask = 4'b0100;
      checkOutput("t5_mux0", o_mux_sel, 0);
      applyStimulus(10'd50);
      repeat (4) applyStimulus(10'd8);
      checkOutput("t5_val0", o_smp_val, 8);
      checkOutput("t5_ch0", o_smp_ch, 0);
      handshake();
      checkOutput("t5_mux1", o_mux_sel, 1);
      checkOutput("t5_nodone", o_scan_done, 0);
      applyStimulus(10'd60);
      repeat (4) applyStimulus(10'd9);
      checkOutput("t5_val1", o_smp_val, 9);
      checkOutput("t5_ch1", o_smp_ch, 1);
      handshake();
      checkOutput("t5_done1", o_scan_done, 1);
      checkOutput("t5_mux2", o_mux_sel, 2);
      checkOutput("t5_busy", o_busy, 1);
      applyStimulus(10'd70);
      applyStimulus(10'd4);
      applyStimulus(10'd5);
      applyStimulus(10'd6);
      applyStimulus(10'd7);
      checkOutput("t5_val2", o_smp_val, 5);
      checkOutput("t5_ch2", o_smp_ch, 2);
      i_en_mask = 4'b0000;
      handshake();
      checkOutput("t5_done2", o_scan_done, 1);
      checkOutput("t5_idle", o_busy, 0);
      i_continuous = 1'b0;
      repeat (3) stepCycle();
      checkOutput("total_scan_done", scanDoneCount, 7);
      checkOutput("total_handshakes", handshakeCount, 9);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequencer that shares the single delta-sigma ADC between up to NUM_CH analog inputs through an external analog multiplexer.
- Drives the mux select and discards conversions contaminated by each channel switch.
- Averages 2^AVG_LOG2 good conversions per channel and hands tagged results to the packet builder over a valid/ready interface.
- Sits between the ADC block and the 100BASE-FX frame assembler.

Parameters:
- NUM_CH, 4, number of analog channels (2..16).
- CH_W, 2, channel index width, equal to clog2(NUM_CH).
- DISCARD, 1, conversions dropped after every mux change (minimum 1, because the in-flight conversion is contaminated).
- AVG_LOG2, 2, log2 of conversions averaged per result (0..4).

Ports:
- i_clk  in  1  system clock
- i_res  in  1  synchronous active-high reset
- i_start  in  1  1-clk start-scan pulse
- i_continuous  in  1  1 = rescan automatically after the last channel
- i_en_mask  in  NUM_CH  channel enable mask, bit n = channel n
- i_adc_val  in  10  ADC conversion result
- i_adc_done  in  1  ADC 1-clk result-valid pulse
- o_mux_sel  out  CH_W  analog mux select
- o_busy  out  1  high whenever state != IDLE
- o_smp_valid  out  1  result valid
- o_smp_ch  out  CH_W  channel of result
- o_smp_val  out  10  averaged result
- i_smp_ready  in  1  downstream accepts result
- o_scan_done  out  1  1-clk pulse when the last enabled channel's result is accepted

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_res.
  - All outputs are 0 on the edge where i_res=1: o_mux_sel, o_busy, o_smp_valid, o_smp_ch, o_smp_val, o_scan_done.
  - State goes to IDLE; accumulator, conversion counter and latched mask clear.
  - Reset mid-operation discards any partial sum and any pending result.
- States: IDLE, SETTLE, SAMPLE, EMIT.
- IDLE:
  - i_start=1 with i_en_mask!=0: latch mask; o_mux_sel <= lowest enabled index; go to SETTLE with counter=0.
  - i_start with mask=0: ignored.
  - i_adc_done: ignored.
- SETTLE:
  - Count i_adc_done pulses; values are discarded.
  - On the DISCARD-th pulse, go to SAMPLE with accumulator=0.
- SAMPLE:
  - Each i_adc_done adds i_adc_val to the accumulator (width 10+AVG_LOG2, no overflow possible).
  - On the 2^AVG_LOG2-th pulse: o_smp_val <= (acc + i_adc_val) >> AVG_LOG2, truncating; o_smp_ch <= o_mux_sel; o_smp_valid <= 1; go to EMIT.
  - Latency: valid is high on the cycle after the final done pulse.
- EMIT:
  - o_smp_valid, o_smp_ch and o_smp_val stay stable until a cycle with i_smp_ready=1. Backpressure may last indefinitely.
  - i_adc_done is ignored while in EMIT; the ADC free-runs and no conversion is buffered.
  - On the handshake cycle, o_smp_valid <= 0 and the controller picks the next channel:
    - Next higher enabled channel in the latched mask exists: o_mux_sel <= it; go to SETTLE.
    - None exists: o_scan_done pulses.
      - i_continuous=1 (sampled that cycle): re-latch i_en_mask. New mask 0 -> IDLE. Otherwise o_mux_sel <= lowest enabled; go to SETTLE.
      - i_continuous=0: go to IDLE.
  - If the next channel equals the current one (single-channel continuous), skip SETTLE and go straight to SAMPLE with accumulator=0; o_mux_sel is unchanged.
- i_start while busy: ignored.
- i_en_mask changes mid-scan: take effect only at the rescan point.
- Clearing i_continuous mid-scan: the current scan finishes, then the block goes to IDLE.
- Simultaneous i_adc_done and handshake in EMIT: the done pulse is ignored.
- Mask bits at or above NUM_CH do not exist.

Decomposition:
- Package adc_pkg:
  - ADC_W=10.
  - State enum {IDLE, SETTLE, SAMPLE, EMIT}.
  - Function for the averaged-result shift.
- Sub-module adc_ch_find (combinational): inputs mask and current index; outputs next-higher enabled index, lowest enabled index, and a found flag. Used in IDLE and EMIT.

Test Plan:
- Reset: hold i_res 3 cycles mid-SAMPLE -> all outputs 0, o_busy=0. Start with mask 4'b0001 and four values 0 -> first result is 0; no stale sum.
- Single scan, mask 4'b1010, i_continuous=0:
  - First result: o_mux_sel=1; first done (val 999) is discarded; vals 100,101,102,103 -> ch1 val 101.
  - Second result: o_mux_sel=3; discard 1 conversion; vals 1023 x4 -> ch3 val 1023.
  - Then o_scan_done pulses once and the block returns to IDLE.
- Backpressure: hold i_smp_ready=0 for 50 cycles with 3 done pulses during that window -> valid/ch/val stable, o_mux_sel unchanged, no extra results. Release -> exactly one handshake, then SETTLE on the next channel.
- Continuous single channel, mask 4'b0001: consecutive results every 4 done pulses with no discard after the first; o_mux_sel stays 0; o_scan_done pulses per result.
- Ignored starts: i_start with mask 0 -> stays IDLE. i_start during SAMPLE -> no effect on the sequence.
- Mask change at rescan: continuous with 4'b0011; change to 4'b0100 mid-scan -> channels 0,1 finish, then channel 2. Change to 0 -> IDLE after scan_done.
